// File: rtl/chu_vga_multi_sprite_core.sv
// chu_vga_multi_sprite_core: NS-sprite 2bpp overlay on the video stream; collision logic under VGA_SPRITE_COLLISION_EN
module chu_vga_multi_sprite_core #(
  parameter int CD        = 12,
  parameter int NS        = 4,
  parameter int SIZE_LOG2 = 4,
  parameter int FRM_LOG2  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);
  localparam int AW = 2*SIZE_LOG2+FRM_LOG2;
  localparam int SZ = 2**SIZE_LOG2;
  localparam int CW = FRM_LOG2+2;
  logic [10:0]         x0_q [NS];
  logic [10:0]         y0_q [NS];
  logic [CW-1:0]       ctrl_q [NS];
  logic [7:0]          period_q [NS];
  logic [7:0]          cnt_q [NS];
  logic [FRM_LOG2-1:0] frame_q [NS];
  logic [CD-1:0]       pal_q [NS][3];
  logic [1:0]          mem [NS][2**AW];
  logic [1:0]          pix_q [NS];
  logic [NS-1:0]       hit_q, hit_d, opq, swe;
  logic [CD-1:0]       rgb1_q, so_d;
  logic [10:0]         dx [NS];
  logic [10:0]         dy [NS];
  logic [AW-1:0]       raddr [NS];
  logic [31:0]         coll_rd;
  logic                bypass_q, xy0_q, we, ram_we, reg_we, glb_we, tick;
  logic                unused_ok;
  assign unused_ok = &{1'b0, read, wr_data, addr};
  assign we     = cs & write;
  assign ram_we = we & ~addr[13];
  assign reg_we = we & addr[13] & ~addr[6];
  assign glb_we = we & addr[13] & addr[6];
  assign tick   = x == 11'd0 && y == 11'd0 && !xy0_q;
  // sprite pixel memories, write-only from the bus and not reset
  always_ff @(posedge clk)
    for (int i = 0; i < NS; i++)
      if (ram_we && addr[12:10] == 3'(i)) mem[i][addr[AW-1:0]] <= wr_data[1:0];
  // per-sprite registers and animation sequencers; a ctrl/period write overrides a same-cycle tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bypass_q <= 1'b0;
      xy0_q    <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        x0_q[i]     <= '0;
        y0_q[i]     <= '0;
        ctrl_q[i]   <= '0;
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
        frame_q[i]  <= '0;
        for (int j = 0; j < 3; j++) pal_q[i][j] <= '0;
      end
    end else begin
      xy0_q <= x == 11'd0 && y == 11'd0;
      if (glb_we && !addr[0]) bypass_q <= wr_data[0];
      for (int i = 0; i < NS; i++) begin
        if (swe[i] && addr[2:0] == 3'd0) x0_q[i] <= wr_data[10:0];
        if (swe[i] && addr[2:0] == 3'd1) y0_q[i] <= wr_data[10:0];
        if (swe[i] && addr[2] && addr[1:0] != 2'd3) pal_q[i][addr[1:0]] <= wr_data[CD-1:0];
        if (swe[i] && addr[2:0] == 3'd2) begin
          ctrl_q[i] <= wr_data[CW-1:0];
          cnt_q[i]  <= '0;
          if (wr_data[1]) frame_q[i] <= wr_data[CW-1:2];
        end else if (swe[i] && addr[2:0] == 3'd3) begin
          period_q[i] <= wr_data[7:0];
          cnt_q[i]    <= '0;
        end else if (tick && ctrl_q[i][0] && ctrl_q[i][1]) begin
          cnt_q[i]   <= cnt_q[i] == period_q[i] ? 8'd0 : cnt_q[i] + 8'd1;
          frame_q[i] <= cnt_q[i] == period_q[i] ? frame_q[i] + FRM_LOG2'(1) : frame_q[i];
        end
      end
    end
  // hit test at 12 bits so sprites near x/y=2047 never wrap, plus RAM address per sprite
  always_comb
    for (int i = 0; i < NS; i++) begin
      swe[i]   = reg_we && addr[5:3] == 3'(i);
      dx[i]    = x - x0_q[i];
      dy[i]    = y - y0_q[i];
      hit_d[i] = {1'b0, x} >= {1'b0, x0_q[i]} && {1'b0, x} < {1'b0, x0_q[i]} + 12'(SZ) &&
                 {1'b0, y} >= {1'b0, y0_q[i]} && {1'b0, y} < {1'b0, y0_q[i]} + 12'(SZ);
      raddr[i] = {ctrl_q[i][1] ? frame_q[i] : ctrl_q[i][CW-1:2], dy[i][SIZE_LOG2-1:0], dx[i][SIZE_LOG2-1:0]};
    end
  // stage 1: sprite pixel codes, hit flags and the incoming colour
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hit_q  <= '0;
      rgb1_q <= '0;
      for (int i = 0; i < NS; i++) pix_q[i] <= '0;
    end else begin
      hit_q  <= hit_d;
      rgb1_q <= si_rgb;
      for (int i = 0; i < NS; i++) pix_q[i] <= mem[i][raddr[i]];
    end
  // stage 2 select: scanning downward leaves the lowest-index opaque sprite on top
  always_comb begin
    so_d = rgb1_q;
    for (int i = NS-1; i >= 0; i--) begin
      opq[i] = ctrl_q[i][0] && hit_q[i] && pix_q[i] != 2'd0;
      if (opq[i]) so_d = pal_q[i][pix_q[i]-2'd1];
    end
    if (bypass_q) so_d = rgb1_q;
  end
  // stage 2 output register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) so_rgb <= '0;
    else so_rgb <= so_d;
`ifdef VGA_SPRITE_COLLISION_EN
  logic [NS-1:0] coll_q;
  logic          coll_clr;
  assign coll_clr = glb_we & addr[0];
  assign coll_rd  = 32'(coll_q);
  // sticky collision bits; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) coll_q <= '0;
    else if ($countones(opq) > 1) coll_q <= (coll_clr ? '0 : coll_q) | opq;
    else if (coll_clr) coll_q <= '0;
`else
  assign coll_rd = '0;
`endif
  // combinational register readback; reserved and absent sprites read 0
  always_comb begin
    rd_data = '0;
    if (addr[13] && addr[6]) rd_data = addr[0] ? coll_rd : {31'd0, bypass_q};
    else if (addr[13])
      for (int i = 0; i < NS; i++)
        if (addr[5:3] == 3'(i))
          case (addr[2:0])
            3'd0:                rd_data = 32'(x0_q[i]);
            3'd1:                rd_data = 32'(y0_q[i]);
            3'd2:                rd_data = 32'(ctrl_q[i]);
            3'd3:                rd_data = 32'(period_q[i]);
            3'd4, 3'd5, 3'd6:    rd_data = 32'(pal_q[i][addr[1:0]]);
            default:             rd_data = '0;
          endcase
  end
endmodule
